// File: rtl/hex_scan_ctrl.sv
// Scan controller for common-anode hex 7-segment digits sharing one external transcoder.
// Optional HEX_SCAN_BLANK_UNWRITTEN_EN: digits that have never been written stay dark.
module hex_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  input  logic              clear,
  output logic [3:0]        nib_out,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] dig_n
);

  localparam int HW = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {BLANK, FETCH, SHOW} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [6:0]      seg_reg, seg_nx;
  logic [HW-1:0]   hist;
  logic            accept;
  logic            dark_digit;

  assign wr_ready = !rst && !clear;
  assign accept   = wr_valid && wr_ready;

`ifdef HEX_SCAN_BLANK_UNWRITTEN_EN
  localparam int FW = $clog2(DIGITS + 1);
  logic [FW-1:0] filled;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      filled <= '0;
    end else if (accept) begin
      if (int'(filled) + 2 >= DIGITS) filled <= FW'(DIGITS);
      else                            filled <= filled + FW'(2);
    end
  end

  assign dark_digit = (int'(idx) >= int'(filled));
`else
  assign dark_digit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      idx     <= IW'(DIGITS - 1);
      cnt     <= '0;
      seg_reg <= 7'h7F;
      nib_out <= '0;
      hist    <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      seg_reg <= seg_nx;
      // Nibble is captured from pre-edge history, so writes landing now are seen next visit.
      if (state == BLANK) nib_out <= hist[4*idx_nx +: 4];
      if (clear)       hist <= '0;
      else if (accept) hist <= HW'({hist, wr_data});
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    seg_nx   = seg_reg;
    dig_n    = '1;
    seg_out  = 7'h7F;
    case (state)
      BLANK: begin
        idx_nx   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        seg_nx   = dark_digit ? 7'h7F : seg_in;
        cnt_nx   = CW'(REFRESH_DIV - 1);
        state_nx = SHOW;
      end
      SHOW: begin
        dig_n[idx] = 1'b0;
        seg_out    = seg_reg;
        if (cnt == '0) state_nx = BLANK;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = BLANK;
    endcase
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl (DIGITS=4, REFRESH_DIV=4): expected digit visits are queued
// by the stimulus thread and checked by a monitor at each digit lighting.
module tb_hex_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       clear;
  logic [3:0] nib_out;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic [3:0] dig_n;

`ifdef HEX_SCAN_BLANK_UNWRITTEN_EN
  localparam logic [6:0] UNW = 7'h7F;
`else
  localparam logic [6:0] UNW = 7'h40;
`endif

  typedef struct {
    int         visit;
    logic [3:0] dig;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecnt     = 0;

  hex_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .clear(clear), .nib_out(nib_out), .seg_in(seg_in), .seg_out(seg_out), .dig_n(dig_n)
  );

  always #5 clk = ~clk;

  // External transcoder: active-low gfedcba.
  always_comb begin
    case (nib_out)
      4'h0: seg_in = 7'h40; 4'h1: seg_in = 7'h79; 4'h2: seg_in = 7'h24; 4'h3: seg_in = 7'h30;
      4'h4: seg_in = 7'h19; 4'h5: seg_in = 7'h12; 4'h6: seg_in = 7'h02; 4'h7: seg_in = 7'h78;
      4'h8: seg_in = 7'h00; 4'h9: seg_in = 7'h10; 4'hA: seg_in = 7'h08; 4'hB: seg_in = 7'h03;
      4'hC: seg_in = 7'h46; 4'hD: seg_in = 7'h21; 4'hE: seg_in = 7'h06; default: seg_in = 7'h0E;
    endcase
  end

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int v, input logic [6:0] s);
    logic [3:0] d;
    d = 4'b0001 << (v % 4);
    exp_q.push_back('{visit: v, dig: ~d, seg: s});
  endtask

  task automatic wait_edge(input int n);
    int budget = 0;
    while (ecnt != n && budget < 1000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (ecnt != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_edge: edge %0d not reached (at %0d)", n, ecnt);
    end
  endtask

  // Monitor: checks blank gap, lit duration, blank segments and each queued visit.
  bit         lit = 0;
  int         lit_len = 0, dark_len = 0, visit = 0;
  logic [3:0] lit_pat;
  logic [6:0] lit_seg;

  always @(negedge clk) begin
    if (rst) begin
      lit = 0; lit_len = 0; dark_len = 0; visit = 0;
    end else if (dig_n == 4'hF) begin
      if (lit) begin
        chk("show_len", lit_len, 4);
        lit = 0;
        dark_len = 0;
      end
      dark_len++;
      chk("dark_seg", {25'd0, seg_out}, 32'h7F);
    end else if (!lit) begin
      chk("gap_len", dark_len, 2);
      lit = 1; lit_len = 1; lit_pat = dig_n; lit_seg = seg_out;
      while (exp_q.size() > 0 && exp_q[0].visit < visit) begin
        chk("visit_missed", exp_q[0].visit, visit);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].visit == visit) begin
        chk("visit_dig", {28'd0, dig_n}, {28'd0, exp_q[0].dig});
        chk("visit_seg", {25'd0, seg_out}, {25'd0, exp_q[0].seg});
        void'(exp_q.pop_front());
      end
      visit++;
    end else begin
      lit_len++;
      chk("lit_stable", {21'd0, dig_n, seg_out}, {21'd0, lit_pat, lit_seg});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig_n", {28'd0, dig_n}, 32'hF);
    chk("rst_seg", {25'd0, seg_out}, 32'h7F);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    rst = 1'b0;
    for (int v = 0; v < 4; v++) push(v, UNW);

    wait_edge(22);
    wr_valid = 1'b1; wr_data = 8'h1C;
    #1 chk("ready_1c", {31'd0, wr_ready}, 32'd1);
    wait_edge(23);
    wr_valid = 1'b0;
    push(4, 7'h46); push(5, 7'h79); push(6, UNW); push(7, UNW);

    wait_edge(45);
    wr_valid = 1'b1; wr_data = 8'h12;
    wait_edge(46);
    wr_data = 8'h34;
    wait_edge(47);
    wr_data = 8'hAB;
    #1 chk("ready_b2b", {31'd0, wr_ready}, 32'd1);
    wait_edge(48);
    wr_valid = 1'b0;
    push(8, 7'h03); push(9, 7'h08); push(10, 7'h19); push(11, 7'h30);

    wait_edge(70);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
    #1 chk("ready_clear", {31'd0, wr_ready}, 32'd0);
    wait_edge(71);
    clear = 1'b0; wr_valid = 1'b0;
    for (int v = 12; v < 16; v++) push(v, UNW);

    wait_edge(97);
    wr_valid = 1'b1; wr_data = 8'hE7;
    wait_edge(98);
    wr_valid = 1'b0;
    push(16, UNW); push(17, 7'h06); push(18, UNW); push(19, UNW); push(20, 7'h78);

    wait_edge(135);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dig_n", {28'd0, dig_n}, 32'hF);
    chk("midrst_seg", {25'd0, seg_out}, 32'h7F);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    rst = 1'b0;
    for (int v = 0; v < 4; v++) push(v, UNW);

    wait_edge(21);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
